// File: rtl/rob_pkg.sv
// Shared reorder-buffer constants and types used by the commit controller and its bench.
package rob_pkg;

    localparam int ROB_DEPTH  = 8;
    localparam int ROB_IDX_W  = 3;
    localparam int REG_ADDR_W = 5;
    localparam int XLEN       = 32;

    typedef logic [ROB_IDX_W-1:0] rob_idx_t;

    // Entry FSM encodings, exported so the bench can name entry states.
    typedef enum logic [1:0] {
        ENTRY_IDLE   = 2'd0,
        ENTRY_WAIT   = 2'd1,
        ENTRY_COMMIT = 2'd2
    } entry_state_t;

endpackage

// File: rtl/rob_ptr.sv
// Modulo-DEPTH pointer with increment enable; used for both head and tail.
module rob_ptr
    import rob_pkg::*;
#(
    parameter int DEPTH = ROB_DEPTH,
    parameter int IDX_W = ROB_IDX_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [IDX_W-1:0] ptr
);

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
        end else if (inc) begin
            ptr <= (ptr == IDX_W'(DEPTH - 1)) ? '0 : ptr + 1'b1;
        end
    end

endmodule

// File: rtl/rob_commit_ctrl.sv
// Reorder-buffer control: in-order allocation, head-entry retirement and register-file write port.
// Optional performance counters are enabled with `define ROB_PERF_CNT_EN.
module rob_commit_ctrl
    import rob_pkg::*;
#(
    parameter int DEPTH = ROB_DEPTH,
    parameter int IDX_W = ROB_IDX_W
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    issue_valid,
    output logic                    issue_ready,
    output logic [DEPTH-1:0]        alloc_sel,
    input  logic [DEPTH-1:0]        entry_busy,
    input  logic [DEPTH-1:0]        entry_wen,
    input  logic [REG_ADDR_W*DEPTH-1:0] entry_dest,
    input  logic [XLEN*DEPTH-1:0]   entry_val,
    output logic [IDX_W-1:0]        head,
    output logic [IDX_W-1:0]        tail,
    output logic [IDX_W:0]          count,
    output logic                    full,
    output logic                    empty,
    output logic                    rf_wen,
    output logic [REG_ADDR_W-1:0]   rf_waddr,
    output logic [XLEN-1:0]         rf_wdata
`ifdef ROB_PERF_CNT_EN
    ,
    output logic [31:0]             perf_commits,
    output logic [31:0]             perf_full_stalls,
    output logic [IDX_W:0]          perf_max_occ
`endif
);

    logic                  alloc;
    logic                  commit;
    logic                  cmt_q;
    logic [IDX_W-1:0]      cidx_q;
    logic [REG_ADDR_W-1:0] cdest_q;

    assign full        = (count == (IDX_W+1)'(DEPTH));
    assign empty       = (count == '0);
    assign issue_ready = ~full;
    assign alloc       = issue_valid & issue_ready;
    assign alloc_sel   = alloc ? (DEPTH'(1) << tail) : '0;
    assign commit      = entry_wen[head] & ~empty;

    rob_ptr #(.DEPTH(DEPTH), .IDX_W(IDX_W)) u_head_ptr (
        .clk (clk),
        .rst (rst),
        .inc (commit),
        .ptr (head)
    );

    rob_ptr #(.DEPTH(DEPTH), .IDX_W(IDX_W)) u_tail_ptr (
        .clk (clk),
        .rst (rst),
        .inc (alloc),
        .ptr (tail)
    );

    // dest is captured at commit because the entry clears it on leaving COMMIT;
    // val is read one cycle later since the CDB result may land in the commit cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            count   <= '0;
            cmt_q   <= 1'b0;
            cidx_q  <= '0;
            cdest_q <= '0;
        end else begin
            case ({alloc, commit})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            cmt_q <= commit;
            if (commit) begin
                cidx_q  <= head;
                cdest_q <= entry_dest[head*REG_ADDR_W +: REG_ADDR_W];
            end
        end
    end

    assign rf_wen   = cmt_q;
    assign rf_waddr = cmt_q ? cdest_q : '0;
    assign rf_wdata = cmt_q ? entry_val[cidx_q*XLEN +: XLEN] : '0;

    // Entry busy flags must track the occupancy, except right after a retire.
    always_ff @(posedge clk) begin
        if (!rst && !cmt_q) begin
            assert (count == (IDX_W+1)'($countones(entry_busy)));
        end
    end

`ifdef ROB_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_commits     <= '0;
            perf_full_stalls <= '0;
            perf_max_occ     <= '0;
        end else begin
            if (commit && (perf_commits != '1)) begin
                perf_commits <= perf_commits + 1'b1;
            end
            if (issue_valid && full && (perf_full_stalls != '1)) begin
                perf_full_stalls <= perf_full_stalls + 1'b1;
            end
            if (count > perf_max_occ) begin
                perf_max_occ <= count;
            end
        end
    end
`endif

endmodule

// File: tb/tb_rob_commit_ctrl.sv
// Directed, table-driven bench for rob_commit_ctrl with a small emulation of entry busy flags.
module tb_rob_commit_ctrl;
    import rob_pkg::*;

    localparam int DEPTH = ROB_DEPTH;
    localparam int IDX_W = ROB_IDX_W;

    logic                        clk = 1'b0;
    logic                        rst = 1'b1;
    logic                        issue_valid = 1'b0;
    logic                        issue_ready;
    logic [DEPTH-1:0]            alloc_sel;
    logic [DEPTH-1:0]            entry_busy = '0;
    logic [DEPTH-1:0]            entry_wen = '0;
    logic [REG_ADDR_W*DEPTH-1:0] entry_dest;
    logic [XLEN*DEPTH-1:0]       entry_val;
    logic [IDX_W-1:0]            head;
    logic [IDX_W-1:0]            tail;
    logic [IDX_W:0]              count;
    logic                        full;
    logic                        empty;
    logic                        rf_wen;
    logic [REG_ADDR_W-1:0]       rf_waddr;
    logic [XLEN-1:0]             rf_wdata;
`ifdef ROB_PERF_CNT_EN
    logic [31:0]                 perf_commits;
    logic [31:0]                 perf_full_stalls;
    logic [IDX_W:0]              perf_max_occ;
`endif

    rob_commit_ctrl #(.DEPTH(DEPTH), .IDX_W(IDX_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .issue_valid (issue_valid),
        .issue_ready (issue_ready),
        .alloc_sel   (alloc_sel),
        .entry_busy  (entry_busy),
        .entry_wen   (entry_wen),
        .entry_dest  (entry_dest),
        .entry_val   (entry_val),
        .head        (head),
        .tail        (tail),
        .count       (count),
        .full        (full),
        .empty       (empty),
        .rf_wen      (rf_wen),
        .rf_waddr    (rf_waddr),
        .rf_wdata    (rf_wdata)
`ifdef ROB_PERF_CNT_EN
        ,
        .perf_commits     (perf_commits),
        .perf_full_stalls (perf_full_stalls),
        .perf_max_occ     (perf_max_occ)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       iv;
        logic [7:0] wen;
        logic [7:0] exp_sel;
        logic       exp_ready;
        logic [2:0] exp_head;
        logic [2:0] exp_tail;
        logic [3:0] exp_count;
        logic       exp_rfwen;
        logic [4:0] exp_waddr;
        logic [31:0] exp_wdata;
    } vec_t;

    vec_t       vecs[$];
    int         checks = 0;
    int         errors = 0;
    logic [7:0] busy_next;

    function automatic vec_t mk(logic r, logic iv, logic [7:0] wen, logic [7:0] sel, logic rdy,
                                logic [2:0] h, logic [2:0] t, logic [3:0] c,
                                logic rfw, logic [4:0] wa, logic [31:0] wd);
        vec_t v;
        v.rst = r; v.iv = iv; v.wen = wen; v.exp_sel = sel; v.exp_ready = rdy;
        v.exp_head = h; v.exp_tail = t; v.exp_count = c;
        v.exp_rfwen = rfw; v.exp_waddr = wa; v.exp_wdata = wd;
        return v;
    endfunction

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Entries become busy when selected and idle once they retire through the head.
    task automatic update_busy(input logic r);
        if (r) begin
            busy_next = '0;
        end else begin
            busy_next = entry_busy | alloc_sel;
            if (entry_busy[head] && entry_wen[head]) busy_next[head] = 1'b0;
        end
    endtask

    task automatic apply_stimulus(input vec_t v, input int idx);
        rst         = v.rst;
        issue_valid = v.iv;
        entry_wen   = v.wen;
        #1;
        check_output($sformatf("v%0d alloc_sel", idx), 32'(alloc_sel), 32'(v.exp_sel));
        check_output($sformatf("v%0d issue_ready", idx), 32'(issue_ready), 32'(v.exp_ready));
        update_busy(v.rst);
        @(posedge clk);
        #1;
        entry_busy = busy_next;
        check_output($sformatf("v%0d head", idx), 32'(head), 32'(v.exp_head));
        check_output($sformatf("v%0d tail", idx), 32'(tail), 32'(v.exp_tail));
        check_output($sformatf("v%0d count", idx), 32'(count), 32'(v.exp_count));
        check_output($sformatf("v%0d full", idx), 32'(full), 32'(v.exp_count == 4'd8));
        check_output($sformatf("v%0d empty", idx), 32'(empty), 32'(v.exp_count == 4'd0));
        check_output($sformatf("v%0d rf_wen", idx), 32'(rf_wen), 32'(v.exp_rfwen));
        if (v.exp_rfwen) begin
            check_output($sformatf("v%0d rf_waddr", idx), 32'(rf_waddr), 32'(v.exp_waddr));
            check_output($sformatf("v%0d rf_wdata", idx), rf_wdata, v.exp_wdata);
        end
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            entry_dest[i*REG_ADDR_W +: REG_ADDR_W] = (i == 0) ? 5'd5 : 5'(8 + i);
            entry_val[i*XLEN +: XLEN] = (i == 0) ? 32'hDEADBEEF : 32'hA000_0000 + 32'(i);
        end

        //          rst iv  wen    sel    rdy h  t  c  rfw wa  wdata
        vecs.push_back(mk(0, 1, 8'h00, 8'h01, 1, 0, 1, 1, 0, 0,  0));
        vecs.push_back(mk(0, 1, 8'h00, 8'h02, 1, 0, 2, 2, 0, 0,  0));
        vecs.push_back(mk(0, 1, 8'h00, 8'h04, 1, 0, 3, 3, 0, 0,  0));
        vecs.push_back(mk(0, 0, 8'h01, 8'h00, 1, 1, 3, 2, 1, 5,  32'hDEADBEEF));
        vecs.push_back(mk(0, 0, 8'h04, 8'h00, 1, 1, 3, 2, 0, 0,  0));
        vecs.push_back(mk(0, 0, 8'h02, 8'h00, 1, 2, 3, 1, 1, 9,  32'hA0000001));
        vecs.push_back(mk(0, 0, 8'h04, 8'h00, 1, 3, 3, 0, 1, 10, 32'hA0000002));
        vecs.push_back(mk(0, 0, 8'h08, 8'h00, 1, 3, 3, 0, 0, 0,  0));
        vecs.push_back(mk(0, 1, 8'h00, 8'h08, 1, 3, 4, 1, 0, 0,  0));
        vecs.push_back(mk(0, 1, 8'h00, 8'h10, 1, 3, 5, 2, 0, 0,  0));
        vecs.push_back(mk(0, 1, 8'h00, 8'h20, 1, 3, 6, 3, 0, 0,  0));
        vecs.push_back(mk(0, 1, 8'h00, 8'h40, 1, 3, 7, 4, 0, 0,  0));
        vecs.push_back(mk(0, 1, 8'h00, 8'h80, 1, 3, 0, 5, 0, 0,  0));
        vecs.push_back(mk(0, 1, 8'h00, 8'h01, 1, 3, 1, 6, 0, 0,  0));
        vecs.push_back(mk(0, 1, 8'h00, 8'h02, 1, 3, 2, 7, 0, 0,  0));
        vecs.push_back(mk(0, 1, 8'h00, 8'h04, 1, 3, 3, 8, 0, 0,  0));
        vecs.push_back(mk(0, 1, 8'h00, 8'h00, 0, 3, 3, 8, 0, 0,  0));
        vecs.push_back(mk(0, 1, 8'h08, 8'h00, 0, 4, 3, 7, 1, 11, 32'hA0000003));
        vecs.push_back(mk(0, 1, 8'h00, 8'h08, 1, 4, 4, 8, 0, 0,  0));
        vecs.push_back(mk(0, 0, 8'h10, 8'h00, 0, 5, 4, 7, 1, 12, 32'hA0000004));
        vecs.push_back(mk(0, 0, 8'h20, 8'h00, 1, 6, 4, 6, 1, 13, 32'hA0000005));
        vecs.push_back(mk(0, 0, 8'h40, 8'h00, 1, 7, 4, 5, 1, 14, 32'hA0000006));
        vecs.push_back(mk(0, 1, 8'h80, 8'h10, 1, 0, 5, 5, 1, 15, 32'hA0000007));
        vecs.push_back(mk(0, 0, 8'h04, 8'h00, 1, 0, 5, 5, 0, 0,  0));
        vecs.push_back(mk(0, 0, 8'h01, 8'h00, 1, 1, 5, 4, 1, 5,  32'hDEADBEEF));

        repeat (2) @(posedge clk);
        #1;
        check_output("reset head", 32'(head), 32'd0);
        check_output("reset tail", 32'(tail), 32'd0);
        check_output("reset count", 32'(count), 32'd0);
        check_output("reset empty", 32'(empty), 32'd1);
        check_output("reset full", 32'(full), 32'd0);
        check_output("reset rf_wen", 32'(rf_wen), 32'd0);
        check_output("reset rf_waddr", 32'(rf_waddr), 32'd0);
        check_output("reset rf_wdata", rf_wdata, 32'd0);
        check_output("reset issue_ready", 32'(issue_ready), 32'd1);
        check_output("reset alloc_sel", 32'(alloc_sel), 32'd0);

        foreach (vecs[i]) apply_stimulus(vecs[i], i);

        // Reset lands in the same cycle as a commit of head=1: the rf write must be dropped.
        rst = 1'b1; issue_valid = 1'b1; entry_wen = 8'h02;
        #1;
        update_busy(1'b1);
        @(posedge clk);
        #1;
        entry_busy = busy_next;
        check_output("midrst rf_wen", 32'(rf_wen), 32'd0);
        check_output("midrst head", 32'(head), 32'd0);
        check_output("midrst tail", 32'(tail), 32'd0);
        check_output("midrst count", 32'(count), 32'd0);
        check_output("midrst empty", 32'(empty), 32'd1);

        rst = 1'b0; issue_valid = 1'b0; entry_wen = 8'h01;
        #1;
        update_busy(1'b0);
        @(posedge clk);
        #1;
        entry_busy = busy_next;
        check_output("empty wen rf_wen", 32'(rf_wen), 32'd0);
        check_output("empty wen head", 32'(head), 32'd0);
        check_output("empty wen count", 32'(count), 32'd0);

        issue_valid = 1'b1; entry_wen = 8'h00;
        #1;
        check_output("post-reset alloc_sel", 32'(alloc_sel), 32'h01);
        update_busy(1'b0);
        @(posedge clk);
        #1;
        entry_busy = busy_next;
        issue_valid = 1'b0;
        check_output("post-reset tail", 32'(tail), 32'd1);
        check_output("post-reset count", 32'(count), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
